// File: rtl/bcd_modn_counter.sv
// rtl/bcd_modn_counter.sv - parametrised packed-BCD modulo-N counter with load, wrap pulse and load-error pulse
//
// Counts 0 .. MODULUS-1 in packed BCD across DIGITS digits (digit 0 in bits [3:0]).
// Optional feature macro: BCD_COUNTER_DOWN_EN
//   defined   -> the up input selects the direction, and down-count/borrow logic is built
//   undefined -> the up input is ignored, and the counter always increments
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset, clears q/co/err
//   en    in   count enable
//   up    in   1 = increment, 0 = decrement (only with BCD_COUNTER_DOWN_EN)
//   load  in   synchronous parallel load request, has priority over en
//   d     in   packed BCD load value
//   q     out  registered packed BCD count
//   co    out  registered one-cycle wrap/borrow pulse, for cascading into the next stage's en
//   err   out  registered one-cycle pulse, load value rejected

module bcd_modn_counter #(
  parameter int MODULUS = 24,
  parameter int DIGITS  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   d,
  output logic [4*DIGITS-1:0]   q,
  output logic                  co,
  output logic                  err
);

  localparam int W = 4 * DIGITS;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int           t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Terminal count in BCD; also the upper bound for accepted load values.
  localparam logic [W-1:0] MAX_BCD = to_bcd(MODULUS - 1);

  logic [W-1:0] r_q;
  logic         r_co;
  logic         r_err;

  logic         w_digits_ok;
  logic         w_load_ok;
  logic [W-1:0] w_inc;
  logic         w_carry;
  logic [W-1:0] w_q_next;
  logic         w_co_next;
  logic         w_err_next;

  // With all digits valid, packed-BCD ordering equals numeric ordering,
  // so value(d) < MODULUS reduces to d <= MAX_BCD.
  always_comb begin
    w_digits_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (d[4*i +: 4] > 4'd9) w_digits_ok = 1'b0;
    end
    w_load_ok = w_digits_ok && (d <= MAX_BCD);
  end

  // Ripple BCD increment; overflow out of the top digit is never used
  // because the terminal count is handled separately.
  always_comb begin
    w_inc   = r_q;
    w_carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_carry) begin
        if (r_q[4*i +: 4] == 4'd9) begin
          w_inc[4*i +: 4] = 4'd0;
        end else begin
          w_inc[4*i +: 4] = r_q[4*i +: 4] + 4'd1;
          w_carry         = 1'b0;
        end
      end
    end
  end

`ifdef BCD_COUNTER_DOWN_EN
  logic [W-1:0] w_dec;
  logic         w_borrow;

  // Ripple BCD decrement; zero is handled separately, so the borrow
  // always terminates inside the digit range.
  always_comb begin
    w_dec    = r_q;
    w_borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_borrow) begin
        if (r_q[4*i +: 4] == 4'd0) begin
          w_dec[4*i +: 4] = 4'd9;
        end else begin
          w_dec[4*i +: 4] = r_q[4*i +: 4] - 4'd1;
          w_borrow        = 1'b0;
        end
      end
    end
  end
`else
  logic w_unused_up;
  assign w_unused_up = up;
`endif

  always_comb begin
    w_q_next   = r_q;
    w_co_next  = 1'b0;
    w_err_next = 1'b0;
    if (load) begin
      // A rejected load still consumes the cycle: no counting.
      if (w_load_ok) w_q_next = d;
      else           w_err_next = 1'b1;
    end else if (en) begin
`ifdef BCD_COUNTER_DOWN_EN
      if (!up) begin
        if (r_q == '0) begin
          w_q_next  = MAX_BCD;
          w_co_next = 1'b1;
        end else begin
          w_q_next = w_dec;
        end
      end else
`endif
      begin
        if (r_q == MAX_BCD) begin
          w_q_next  = '0;
          w_co_next = 1'b1;
        end else begin
          w_q_next = w_inc;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q   <= '0;
      r_co  <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_q   <= w_q_next;
      r_co  <= w_co_next;
      r_err <= w_err_next;
    end
  end

  assign q   = r_q;
  assign co  = r_co;
  assign err = r_err;

endmodule
